// File: rtl/axi4_operand_ram.sv
`timescale 1ns/1ps
// axi4_operand_ram
//   AXI4 slave RAM used as the operand/result store of the ALU CPU master and
//   as a general memory for other masters on the interconnect. Word-addressed
//   synchronous RAM with independent read and write FSMs, each handling one
//   transaction at a time. Supports single beats and INCR/FIXED bursts (WRAP
//   is handled as INCR) with byte strobes.
//
// Ports
//   ACLK, ARESET           clock (rising edge), synchronous active-high reset
//   S_AXI_aw*              write address channel (lock/cache/prot/region/qos ignored)
//   S_AXI_w*               write data channel (wlast ignored; beat count comes from awlen)
//   S_AXI_b*               write response channel
//   S_AXI_ar*              read address channel (lock/cache/prot/region/qos ignored)
//   S_AXI_r*               read data channel
//
// Build option
//   AXI_RAM_ADDR_CHECK_EN  when defined, beats outside
//                          [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8) are
//                          errors: writes dropped, reads return 0, SLVERR given.
//                          When undefined, the word index wraps mod MEM_DEPTH
//                          and responses are always OKAY.
module axi4_operand_ram #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,

  input  logic [ADDR_WIDTH-1:0]     S_AXI_awaddr,
  input  logic [7:0]                S_AXI_awlen,
  input  logic [2:0]                S_AXI_awsize,
  input  logic [1:0]                S_AXI_awburst,
  input  logic [1:0]                S_AXI_awlock,
  input  logic [3:0]                S_AXI_awcache,
  input  logic [2:0]                S_AXI_awprot,
  input  logic [3:0]                S_AXI_awregion,
  input  logic [3:0]                S_AXI_awqos,
  input  logic                      S_AXI_awvalid,
  output logic                      S_AXI_awready,

  input  logic [DATA_WIDTH-1:0]     S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_wstrb,
  input  logic                      S_AXI_wlast,
  input  logic                      S_AXI_wvalid,
  output logic                      S_AXI_wready,

  output logic [1:0]                S_AXI_bresp,
  output logic                      S_AXI_bvalid,
  input  logic                      S_AXI_bready,

  input  logic [ADDR_WIDTH-1:0]     S_AXI_araddr,
  input  logic [7:0]                S_AXI_arlen,
  input  logic [2:0]                S_AXI_arsize,
  input  logic [1:0]                S_AXI_arburst,
  input  logic [1:0]                S_AXI_arlock,
  input  logic [3:0]                S_AXI_arcache,
  input  logic [2:0]                S_AXI_arprot,
  input  logic [3:0]                S_AXI_arregion,
  input  logic [3:0]                S_AXI_arqos,
  input  logic                      S_AXI_arvalid,
  output logic                      S_AXI_arready,

  output logic [DATA_WIDTH-1:0]     S_AXI_rdata,
  output logic [1:0]                S_AXI_rresp,
  output logic                      S_AXI_rlast,
  output logic                      S_AXI_rvalid,
  input  logic                      S_AXI_rready
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Word number relative to BASE_ADDR (before any wrap).
  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> ADDR_LSB;
  endfunction

  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(word_of(a) % ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  // FIXED holds the address; INCR and WRAP both advance by the beat size.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    return (burst == BURST_FIXED) ? a : a + (ADDR_WIDTH'(1) << size);
  endfunction

`ifdef AXI_RAM_ADDR_CHECK_EN
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && (word_of(a) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t               w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [7:0]             w_cnt;
  logic [2:0]             w_size;
  logic [1:0]             w_burst;
  logic                   w_err;
  logic                   aw_fire, w_fire;
  logic                   w_beat_ok;
  logic [IDX_W-1:0]       w_idx;

  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_awready = 1'b0;
    S_AXI_wready  = 1'b0;
    S_AXI_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_awready = 1'b1;
        if (S_AXI_awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        S_AXI_wready = 1'b1;
        if (S_AXI_wvalid && (w_cnt == '0)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_bvalid = 1'b1;
        if (S_AXI_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_fire     = S_AXI_awvalid && S_AXI_awready;
  assign w_fire      = S_AXI_wvalid  && S_AXI_wready;
  assign w_idx       = index_of(w_addr);
  assign S_AXI_bresp = w_err ? RESP_SLVERR : RESP_OKAY;

`ifdef AXI_RAM_ADDR_CHECK_EN
  assign w_beat_ok = in_range(w_addr);
`else
  assign w_beat_ok = 1'b1;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_addr  <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_addr  <= S_AXI_awaddr;
      w_cnt   <= S_AXI_awlen;
      w_size  <= S_AXI_awsize;
      w_burst <= S_AXI_awburst;
      w_err   <= 1'b0;
    end else if (w_fire) begin
      w_addr <= next_addr(w_addr, w_size, w_burst);
      w_cnt  <= w_cnt - 8'd1;
      if (!w_beat_ok) w_err <= 1'b1;
    end
  end

  // Memory array carries no reset so its contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_fire && w_beat_ok) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (S_AXI_wstrb[b]) mem[w_idx][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t               r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;      // address of the beat after the one presented
  logic [7:0]             r_cnt;       // beats remaining after the one presented
  logic [2:0]             r_size;
  logic [1:0]             r_burst;
  logic                   ar_fire, r_fire;
  logic [ADDR_WIDTH-1:0]  r_ld_addr;
  logic [IDX_W-1:0]       r_ld_idx;
  logic                   r_ld_ok;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_arready = 1'b0;
    S_AXI_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_arready = 1'b1;
        if (S_AXI_arvalid) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        S_AXI_rvalid = 1'b1;
        if (S_AXI_rready && S_AXI_rlast) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_fire   = S_AXI_arvalid && S_AXI_arready;
  assign r_fire    = S_AXI_rvalid  && S_AXI_rready;
  // The first beat loads straight from araddr; later beats from the tracked address.
  assign r_ld_addr = (r_state == R_IDLE) ? S_AXI_araddr : r_addr;
  assign r_ld_idx  = index_of(r_ld_addr);

`ifdef AXI_RAM_ADDR_CHECK_EN
  assign r_ld_ok = in_range(r_ld_addr);
`else
  assign r_ld_ok = 1'b1;
`endif

  // rdata/rresp/rlast only change on AR acceptance or an accepted non-last
  // beat, so they hold steady while the master stalls.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_rdata <= '0;
      S_AXI_rresp <= RESP_OKAY;
      S_AXI_rlast <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
    end else if (ar_fire) begin
      r_size      <= S_AXI_arsize;
      r_burst     <= S_AXI_arburst;
      r_addr      <= next_addr(S_AXI_araddr, S_AXI_arsize, S_AXI_arburst);
      r_cnt       <= S_AXI_arlen;
      S_AXI_rlast <= (S_AXI_arlen == 8'd0);
      S_AXI_rdata <= r_ld_ok ? mem[r_ld_idx] : '0;
      S_AXI_rresp <= r_ld_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_fire && !S_AXI_rlast) begin
      r_addr      <= next_addr(r_addr, r_size, r_burst);
      r_cnt       <= r_cnt - 8'd1;
      S_AXI_rlast <= (r_cnt == 8'd1);
      S_AXI_rdata <= r_ld_ok ? mem[r_ld_idx] : '0;
      S_AXI_rresp <= r_ld_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Sideband fields are accepted but have no effect on this memory.
  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_awlock, S_AXI_awcache, S_AXI_awprot, S_AXI_awregion,
                       S_AXI_awqos, S_AXI_wlast, S_AXI_arlock, S_AXI_arcache,
                       S_AXI_arprot, S_AXI_arregion, S_AXI_arqos};

endmodule

// File: tb/tb_axi4_operand_ram.sv
`timescale 1ns/1ps
module tb_axi4_operand_ram;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] S_AXI_awaddr;
  logic [7:0]  S_AXI_awlen;
  logic [2:0]  S_AXI_awsize;
  logic [1:0]  S_AXI_awburst;
  logic [1:0]  S_AXI_awlock;
  logic [3:0]  S_AXI_awcache;
  logic [2:0]  S_AXI_awprot;
  logic [3:0]  S_AXI_awregion;
  logic [3:0]  S_AXI_awqos;
  logic        S_AXI_awvalid;
  logic        S_AXI_awready;
  logic [31:0] S_AXI_wdata;
  logic [3:0]  S_AXI_wstrb;
  logic        S_AXI_wlast;
  logic        S_AXI_wvalid;
  logic        S_AXI_wready;
  logic [1:0]  S_AXI_bresp;
  logic        S_AXI_bvalid;
  logic        S_AXI_bready;
  logic [31:0] S_AXI_araddr;
  logic [7:0]  S_AXI_arlen;
  logic [2:0]  S_AXI_arsize;
  logic [1:0]  S_AXI_arburst;
  logic [1:0]  S_AXI_arlock;
  logic [3:0]  S_AXI_arcache;
  logic [2:0]  S_AXI_arprot;
  logic [3:0]  S_AXI_arregion;
  logic [3:0]  S_AXI_arqos;
  logic        S_AXI_arvalid;
  logic        S_AXI_arready;
  logic [31:0] S_AXI_rdata;
  logic [1:0]  S_AXI_rresp;
  logic        S_AXI_rlast;
  logic        S_AXI_rvalid;
  logic        S_AXI_rready;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] WRAP  = 2'b10;

`ifdef AXI_RAM_ADDR_CHECK_EN
  localparam logic [1:0]  OOR_RESP  = 2'b10;
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;
  localparam logic [31:0] MEM0_EXP  = 32'h1234_5678;
`else
  localparam logic [1:0]  OOR_RESP  = 2'b00;
  localparam logic [31:0] OOR_RDATA = 32'h0BAD_F00D;
  localparam logic [31:0] MEM0_EXP  = 32'h0BAD_F00D;
`endif

  axi4_operand_ram #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (1024),
    .BASE_ADDR  (32'h0)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .S_AXI_awaddr   (S_AXI_awaddr),
    .S_AXI_awlen    (S_AXI_awlen),
    .S_AXI_awsize   (S_AXI_awsize),
    .S_AXI_awburst  (S_AXI_awburst),
    .S_AXI_awlock   (S_AXI_awlock),
    .S_AXI_awcache  (S_AXI_awcache),
    .S_AXI_awprot   (S_AXI_awprot),
    .S_AXI_awregion (S_AXI_awregion),
    .S_AXI_awqos    (S_AXI_awqos),
    .S_AXI_awvalid  (S_AXI_awvalid),
    .S_AXI_awready  (S_AXI_awready),
    .S_AXI_wdata    (S_AXI_wdata),
    .S_AXI_wstrb    (S_AXI_wstrb),
    .S_AXI_wlast    (S_AXI_wlast),
    .S_AXI_wvalid   (S_AXI_wvalid),
    .S_AXI_wready   (S_AXI_wready),
    .S_AXI_bresp    (S_AXI_bresp),
    .S_AXI_bvalid   (S_AXI_bvalid),
    .S_AXI_bready   (S_AXI_bready),
    .S_AXI_araddr   (S_AXI_araddr),
    .S_AXI_arlen    (S_AXI_arlen),
    .S_AXI_arsize   (S_AXI_arsize),
    .S_AXI_arburst  (S_AXI_arburst),
    .S_AXI_arlock   (S_AXI_arlock),
    .S_AXI_arcache  (S_AXI_arcache),
    .S_AXI_arprot   (S_AXI_arprot),
    .S_AXI_arregion (S_AXI_arregion),
    .S_AXI_arqos    (S_AXI_arqos),
    .S_AXI_arvalid  (S_AXI_arvalid),
    .S_AXI_arready  (S_AXI_arready),
    .S_AXI_rdata    (S_AXI_rdata),
    .S_AXI_rresp    (S_AXI_rresp),
    .S_AXI_rlast    (S_AXI_rlast),
    .S_AXI_rvalid   (S_AXI_rvalid),
    .S_AXI_rready   (S_AXI_rready)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [127:0] data,
                          input logic [3:0] strb, input logic [1:0] eresp,
                          input int unsigned bstall);
    S_AXI_awaddr  = addr;
    S_AXI_awlen   = len;
    S_AXI_awsize  = 3'd2;
    S_AXI_awburst = burst;
    S_AXI_awvalid = 1'b1;
    chk({tag, "/awready_idle"}, 32'(S_AXI_awready), 32'd1);
    chk({tag, "/wready_idle"},  32'(S_AXI_wready),  32'd0);
    step();
    S_AXI_awvalid = 1'b0;
    chk({tag, "/awready_busy"}, 32'(S_AXI_awready), 32'd0);
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      S_AXI_wdata  = data[32*i +: 32];
      S_AXI_wstrb  = strb;
      S_AXI_wlast  = (i == 32'(len));
      S_AXI_wvalid = 1'b1;
      chk({tag, "/wready"},     32'(S_AXI_wready), 32'd1);
      chk({tag, "/bvalid_early"}, 32'(S_AXI_bvalid), 32'd0);
      step();
    end
    S_AXI_wvalid = 1'b0;
    S_AXI_wlast  = 1'b0;
    chk({tag, "/wready_done"}, 32'(S_AXI_wready), 32'd0);
    chk({tag, "/bvalid"},      32'(S_AXI_bvalid), 32'd1);
    chk({tag, "/bresp"},       32'(S_AXI_bresp),  32'(eresp));
    for (int unsigned i = 0; i < bstall; i++) begin
      step();
      chk({tag, "/bvalid_stall"},  32'(S_AXI_bvalid),  32'd1);
      chk({tag, "/bresp_stall"},   32'(S_AXI_bresp),   32'(eresp));
      chk({tag, "/awready_stall"}, 32'(S_AXI_awready), 32'd0);
    end
    S_AXI_bready = 1'b1;
    step();
    S_AXI_bready = 1'b0;
    chk({tag, "/bvalid_clr"},  32'(S_AXI_bvalid),  32'd0);
    chk({tag, "/awready_ret"}, 32'(S_AXI_awready), 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [127:0] exp,
                         input logic [1:0] eresp, input bit toggle);
    int unsigned beat;
    int unsigned cyc;
    bit stall;
    beat = 0;
    cyc  = 0;
    S_AXI_araddr  = addr;
    S_AXI_arlen   = len;
    S_AXI_arsize  = 3'd2;
    S_AXI_arburst = burst;
    S_AXI_arvalid = 1'b1;
    chk({tag, "/arready_idle"}, 32'(S_AXI_arready), 32'd1);
    step();
    S_AXI_arvalid = 1'b0;
    stall = toggle;
    while (beat <= 32'(len) && cyc < 40) begin
      chk({tag, "/rvalid"},  32'(S_AXI_rvalid),  32'd1);
      chk({tag, "/rdata"},   S_AXI_rdata,        exp[32*beat +: 32]);
      chk({tag, "/rlast"},   32'(S_AXI_rlast),   32'(beat == 32'(len)));
      chk({tag, "/rresp"},   32'(S_AXI_rresp),   32'(eresp));
      chk({tag, "/arready_busy"}, 32'(S_AXI_arready), 32'd0);
      S_AXI_rready = !stall;
      step();
      if (!stall) beat++;
      if (toggle) stall = !stall;
      cyc++;
    end
    S_AXI_rready = 1'b0;
    chk({tag, "/beats"},       beat,                  32'(len) + 32'd1);
    chk({tag, "/rvalid_clr"},  32'(S_AXI_rvalid),  32'd0);
    chk({tag, "/arready_ret"}, 32'(S_AXI_arready), 32'd1);
  endtask

  initial begin
    ARESET         = 1'b1;
    S_AXI_awaddr   = '0;
    S_AXI_awlen    = '0;
    S_AXI_awsize   = 3'd2;
    S_AXI_awburst  = INCR;
    S_AXI_awlock   = '0;
    S_AXI_awcache  = '0;
    S_AXI_awprot   = '0;
    S_AXI_awregion = '0;
    S_AXI_awqos    = '0;
    S_AXI_awvalid  = 1'b0;
    S_AXI_wdata    = '0;
    S_AXI_wstrb    = '0;
    S_AXI_wlast    = 1'b0;
    S_AXI_wvalid   = 1'b0;
    S_AXI_bready   = 1'b0;
    S_AXI_araddr   = '0;
    S_AXI_arlen    = '0;
    S_AXI_arsize   = 3'd2;
    S_AXI_arburst  = INCR;
    S_AXI_arlock   = '0;
    S_AXI_arcache  = '0;
    S_AXI_arprot   = '0;
    S_AXI_arregion = '0;
    S_AXI_arqos    = '0;
    S_AXI_arvalid  = 1'b0;
    S_AXI_rready   = 1'b0;

    // Reset held for two edges.
    step();
    step();
    chk("rst/awready", 32'(S_AXI_awready), 32'd1);
    chk("rst/wready",  32'(S_AXI_wready),  32'd0);
    chk("rst/bvalid",  32'(S_AXI_bvalid),  32'd0);
    chk("rst/bresp",   32'(S_AXI_bresp),   32'd0);
    chk("rst/arready", 32'(S_AXI_arready), 32'd1);
    chk("rst/rvalid",  32'(S_AXI_rvalid),  32'd0);
    chk("rst/rdata",   S_AXI_rdata,        32'd0);
    chk("rst/rresp",   32'(S_AXI_rresp),   32'd0);
    chk("rst/rlast",   32'(S_AXI_rlast),   32'd0);
    ARESET = 1'b0;
    step();

    // Single write then read back.
    do_write("wr10", 32'h10, 8'd0, INCR, {96'd0, 32'hDEAD_BEEF}, 4'hF, 2'b00, 0);
    do_read ("rd10", 32'h10, 8'd0, INCR, {96'd0, 32'hDEAD_BEEF}, 2'b00, 1'b0);

    // Partial strobe merges into prior contents.
    do_write("wr20a", 32'h20, 8'd0, INCR, {96'd0, 32'hAABB_CCDD}, 4'hF, 2'b00, 0);
    do_write("wr20b", 32'h20, 8'd0, INCR, {96'd0, 32'h1122_3344}, 4'h3, 2'b00, 0);
    do_read ("rd20",  32'h20, 8'd0, INCR, {96'd0, 32'hAABB_3344}, 2'b00, 1'b0);

    // INCR burst, read back with rready toggling.
    do_write("wr40", 32'h40, 8'd3, INCR, {32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 2'b00, 0);
    do_read ("rd40", 32'h40, 8'd3, INCR, {32'd4, 32'd3, 32'd2, 32'd1}, 2'b00, 1'b1);

    // FIXED read burst repeats the same word.
    do_read ("rd40f", 32'h40, 8'd1, FIXED, {64'd0, 32'd1, 32'd1}, 2'b00, 1'b0);

    // B stall, then FIXED write burst: only the last beat lands, neighbour untouched.
    do_write("wr84", 32'h84, 8'd0, INCR, {96'd0, 32'hCAFE_F00D}, 4'hF, 2'b00, 0);
    do_write("wr60stall", 32'h60, 8'd0, INCR, {96'd0, 32'h0000_0077}, 4'hF, 2'b00, 5);
    do_write("wr80f", 32'h80, 8'd1, FIXED, {64'd0, 32'd6, 32'd5}, 4'hF, 2'b00, 0);
    do_read ("rd80",  32'h80, 8'd1, INCR, {64'd0, 32'hCAFE_F00D, 32'd6}, 2'b00, 1'b0);

    // WRAP behaves as INCR.
    do_write("wr100w", 32'h100, 8'd1, WRAP, {64'd0, 32'h0000_000B, 32'h0000_000A}, 4'hF, 2'b00, 0);
    do_read ("rd100",  32'h100, 8'd1, INCR, {64'd0, 32'h0000_000B, 32'h0000_000A}, 2'b00, 1'b0);

    // Out-of-range address 0x1000 (wraps to word 0 without the check).
    do_write("wr0",    32'h0,    8'd0, INCR, {96'd0, 32'h1234_5678}, 4'hF, 2'b00, 0);
    do_write("wr1000", 32'h1000, 8'd0, INCR, {96'd0, 32'h0BAD_F00D}, 4'hF, OOR_RESP, 0);
    do_read ("rd1000", 32'h1000, 8'd0, INCR, {96'd0, OOR_RDATA}, OOR_RESP, 1'b0);
    do_read ("rd0",    32'h0,    8'd0, INCR, {96'd0, MEM0_EXP}, 2'b00, 1'b0);

    // Same-edge write and read load of one word: read sees old data.
    do_write("wr200a", 32'h200, 8'd0, INCR, {96'd0, 32'h1111_1111}, 4'hF, 2'b00, 0);
    S_AXI_awaddr  = 32'h200;
    S_AXI_awlen   = 8'd0;
    S_AXI_awburst = INCR;
    S_AXI_awvalid = 1'b1;
    step();
    S_AXI_awvalid = 1'b0;
    S_AXI_wdata   = 32'h2222_2222;
    S_AXI_wstrb   = 4'hF;
    S_AXI_wlast   = 1'b1;
    S_AXI_wvalid  = 1'b1;
    S_AXI_araddr  = 32'h200;
    S_AXI_arlen   = 8'd0;
    S_AXI_arburst = INCR;
    S_AXI_arvalid = 1'b1;
    step();
    S_AXI_wvalid  = 1'b0;
    S_AXI_wlast   = 1'b0;
    S_AXI_arvalid = 1'b0;
    chk("coll/rvalid", 32'(S_AXI_rvalid), 32'd1);
    chk("coll/rdata",  S_AXI_rdata,       32'h1111_1111);
    chk("coll/bvalid", 32'(S_AXI_bvalid), 32'd1);
    S_AXI_bready = 1'b1;
    S_AXI_rready = 1'b1;
    step();
    S_AXI_bready = 1'b0;
    S_AXI_rready = 1'b0;
    chk("coll/rvalid_clr", 32'(S_AXI_rvalid), 32'd0);
    chk("coll/bvalid_clr", 32'(S_AXI_bvalid), 32'd0);
    do_read("rd200", 32'h200, 8'd0, INCR, {96'd0, 32'h2222_2222}, 2'b00, 1'b0);

    // Reset in the middle of a write burst abandons it.
    S_AXI_awaddr  = 32'hC0;
    S_AXI_awlen   = 8'd3;
    S_AXI_awburst = INCR;
    S_AXI_awvalid = 1'b1;
    step();
    S_AXI_awvalid = 1'b0;
    S_AXI_wdata   = 32'h5555_5555;
    S_AXI_wstrb   = 4'hF;
    S_AXI_wvalid  = 1'b1;
    step();
    S_AXI_wvalid  = 1'b0;
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    chk("mrst/awready", 32'(S_AXI_awready), 32'd1);
    chk("mrst/wready",  32'(S_AXI_wready),  32'd0);
    chk("mrst/bvalid",  32'(S_AXI_bvalid),  32'd0);
    chk("mrst/arready", 32'(S_AXI_arready), 32'd1);
    step();
    chk("mrst/bvalid_after", 32'(S_AXI_bvalid), 32'd0);
    chk("mrst/rvalid_after", 32'(S_AXI_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_operand_ram.md
# axi4_operand_ram

- AXI4 slave memory that serves as the data store for the ALU CPU master.
- The master reads operands from this block over AR/R and writes results back over AW/W/B.
- Word-addressed synchronous RAM behind independent read and write FSMs; each FSM handles one transaction at a time.
- Supports single-beat and INCR/FIXED bursts with byte strobes, so the same block also backs other masters in the interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; multiple of 8
- MEM_DEPTH, 1024, number of DATA_WIDTH words
- BASE_ADDR, 32'h0, byte address of word 0

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- S_AXI_awaddr/awlen/awsize/awburst  in  ADDR_WIDTH/8/3/2  write address, beats-1, bytes/beat log2, burst type
- S_AXI_awlock/awcache/awprot/awregion/awqos  in  2/4/3/4/4  accepted, ignored
- S_AXI_awvalid  in  1 / S_AXI_awready  out  1  AW handshake
- S_AXI_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data, byte enables, last flag
- S_AXI_wvalid  in  1 / S_AXI_wready  out  1  W handshake
- S_AXI_bresp  out  2 / S_AXI_bvalid  out  1 / S_AXI_bready  in  1  write response
- S_AXI_araddr/arlen/arsize/arburst  in  ADDR_WIDTH/8/3/2  read address fields
- S_AXI_arlock/arcache/arprot/arregion/arqos  in  2/4/3/4/4  accepted, ignored
- S_AXI_arvalid  in  1 / S_AXI_arready  out  1  AR handshake
- S_AXI_rdata/rresp/rlast  out  DATA_WIDTH/2/1  read data, response, last beat
- S_AXI_rvalid  out  1 / S_AXI_rready  in  1  R handshake

## Operation
Word addressing:
- index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8).
- Without the address check (see Configuration), index is taken mod MEM_DEPTH.

Burst address update per beat:
- INCR: addr += 1<<size.
- FIXED: addr unchanged.
- WRAP (2'b10): treated as INCR.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On AW handshake, latch addr, len, size, burst; set beat counter=len; go W_DATA.
- W_DATA: wready=1. On each W handshake, write the bytes whose wstrb bit is 1; update addr; decrement counter. On the handshake with counter==0, go W_RESP.
- End of burst is set by the counter only. wlast is ignored.
- W_RESP: bvalid=1, held with bresp stable until bready; then go W_IDLE.

Read FSM (R_IDLE, R_DATA):
- R_IDLE: arready=1. On AR handshake, latch fields; load rdata=mem[index]; rlast=(arlen==0); go R_DATA.
- R_DATA: rvalid=1. On R handshake with rlast=0, load the next beat's word and update rlast in the same edge. On R handshake with rlast=1, clear rvalid and go R_IDLE.
- rdata, rresp and rlast are stable while rvalid=1 and rready=0.

Read/write interaction:
- The read and write FSMs run fully in parallel.
- If a read load and a W write hit the same word on the same edge, the read returns the old data.

Response codes: bresp/rresp = 2'b00 (OKAY) unless the address check flags an error.

## Timing
Reset values:
- ARESET high for one edge forces: awready=1, wready=0, bvalid=0, bresp=0, arready=1, rvalid=0, rdata=0, rresp=0, rlast=0.
- Both FSMs return to idle.
- Memory contents are not cleared.
- Reset during a burst abandons it; no B or R beat follows.

Latency:
- AW handshake at edge N → wready=1 from N+1.
- Final W handshake at edge M → bvalid=1 from M+1.
- AR handshake at edge N → first rvalid=1 from N+1.
- Bursts with rready held high stream one beat per cycle.
- Back-to-back single write: AW → B = 2 cycles minimum. New AW is accepted the cycle after the B handshake.
- Back-to-back single read: AR → R = 1 cycle. New AR is accepted the cycle after the rlast handshake.

Handshake rules:
- awready and wready are never both 1.
- arready=0 whenever rvalid=1.
- Valid outputs never drop without their handshake.

## Configuration
Macro AXI_RAM_ADDR_CHECK_EN:
- Defined:
  - Any beat whose byte address lies outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH·DATA_WIDTH/8) is an error beat.
  - Error write beats are dropped (memory unchanged). bresp=2'b10 (SLVERR) if any beat of the burst was in error.
  - Error read beats return rdata=0 and rresp=2'b10. In-range beats of the same burst return OKAY.
- Undefined: no range check; index wraps mod MEM_DEPTH; responses are always OKAY.

## Test plan
- Reset: hold ARESET 2 cycles → all outputs at their reset values; awready=arready=1.
- Single write then read:
  - Stimulus: AW addr 0x10, len 0; W 0xDEADBEEF, strb 0xF; then AR 0x10.
  - Required: bvalid 2 cycles after AW, bresp=0. Then rdata=0xDEADBEEF, rlast=1, rresp=0.
- Strobe:
  - Stimulus: write 0x11223344 to 0x20 with strb 0x3 over prior 0xAABBCCDD.
  - Required: readback 0xAABB3344.
- INCR burst with backpressure:
  - Stimulus: write len 3 at 0x40, data 1,2,3,4; read len 3 at 0x40 with rready toggling every cycle.
  - Required: beats 1,2,3,4 in order; rlast only on the 4th; data stable during stalls.
- Write-response stall and FIXED burst:
  - Stimulus: hold bready=0 for 5 cycles; then a FIXED len 1 write at 0x80 with data 5,6.
  - Required: bvalid held all 5 cycles, no new awready. Then mem[0x80]=6.
- Address check (AXI_RAM_ADDR_CHECK_EN, MEM_DEPTH 1024):
  - Stimulus: write 0x1000 then read 0x1000.
  - Required: bresp=2'b10; rresp=2'b10 with rdata=0; mem[0] unchanged.
  - Same stimulus without the macro: mem[0] is written, and both responses are OKAY.
